// File: rtl/morse_encoder.sv
// Keypad-value to Morse on-off keying encoder: one 4-bit symbol per valid/ready
// handshake, emitted as timed marks and spaces on tx_out, with a done pulse.
module morse_encoder #(
    parameter int UNIT_CYCLES = 3_000_000,
    parameter int CNT_W       = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sym_val,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(UNIT_CYCLES - 1);

    // {len[2:0], pat[4:0]}; pattern is left-justified, MSB first, 1 = dash
    function automatic logic [7:0] morse_code(input logic [3:0] v);
        logic [7:0] c;
        case (v)
            4'h0:    c = {3'd5, 5'b11111};
            4'h1:    c = {3'd5, 5'b01111};
            4'h2:    c = {3'd5, 5'b00111};
            4'h3:    c = {3'd5, 5'b00011};
            4'h4:    c = {3'd5, 5'b00001};
            4'h5:    c = {3'd5, 5'b00000};
            4'h6:    c = {3'd5, 5'b10000};
            4'h7:    c = {3'd5, 5'b11000};
            4'h8:    c = {3'd5, 5'b11100};
            4'h9:    c = {3'd5, 5'b11110};
            4'hA:    c = {3'd2, 5'b01000};
            4'hB:    c = {3'd4, 5'b10000};
            4'hC:    c = {3'd4, 5'b10100};
            4'hD:    c = {3'd3, 5'b10000};
            4'hE:    c = {3'd1, 5'b00000};
            4'hF:    c = {3'd4, 5'b00100};
            default: c = {3'd1, 5'b00000};
        endcase
        return c;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic [1:0]       unit_cnt_r;
    logic [2:0]       elem_left_r;
    logic [4:0]       pat_r;
    logic             tx_out_r;
    logic             done_r;
    logic [1:0]       units_s;
    logic             state_done_s;
    logic             accept_s;
    logic [7:0]       code_s;

    // Next-state decode: a state ends on the last cycle of its final unit
    always_comb begin
        state_s      = state_r;
        units_s      = 2'd1;
        accept_s     = (state_r == ST_IDLE) && sym_valid;
        code_s       = morse_code(sym_val);
        case (state_r)
            ST_MARK:  units_s = pat_r[4] ? 2'd3 : 2'd1;
            ST_GAP:   units_s = 2'd3;
            default:  units_s = 2'd1;
        endcase
        state_done_s = (cyc_cnt_r == CYC_LAST) && (unit_cnt_r == (units_s - 2'd1));
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_MARK;
                else          state_s = ST_IDLE;
            end
            ST_MARK: begin
                if (!state_done_s)           state_s = ST_MARK;
                else if (elem_left_r > 3'd1) state_s = ST_SPACE;
                else                         state_s = ST_GAP;
            end
            ST_SPACE: begin
                if (state_done_s) state_s = ST_MARK;
                else              state_s = ST_SPACE;
            end
            ST_GAP: begin
                if (state_done_s) state_s = ST_IDLE;
                else              state_s = ST_GAP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, registered outputs and unit timer (cleared on every state entry)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tx_out_r   <= 1'b0;
            done_r     <= 1'b0;
            cyc_cnt_r  <= '0;
            unit_cnt_r <= 2'd0;
        end else begin
            state_r  <= state_s;
            tx_out_r <= (state_s == ST_MARK);
            done_r   <= (state_r == ST_GAP) && (state_s == ST_IDLE);
            if ((state_s != state_r) || (state_r == ST_IDLE)) begin
                cyc_cnt_r  <= '0;
                unit_cnt_r <= 2'd0;
            end else if (cyc_cnt_r == CYC_LAST) begin
                cyc_cnt_r  <= '0;
                unit_cnt_r <= unit_cnt_r + 2'd1;
            end else begin
                cyc_cnt_r  <= cyc_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Symbol shift register: latched on accept, advanced after each space
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_r       <= 5'd0;
            elem_left_r <= 3'd0;
        end else if (accept_s) begin
            pat_r       <= code_s[4:0];
            elem_left_r <= code_s[7:5];
        end else if ((state_r == ST_SPACE) && state_done_s) begin
            pat_r       <= {pat_r[3:0], 1'b0};
            elem_left_r <= elem_left_r - 3'd1;
        end
    end

    assign tx_out    = tx_out_r;
    assign done      = done_r;
    assign sym_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);

endmodule
